alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Parametrised, handshaked successor to the combinational IDIOT ALU. It accepts one
//   operation per transaction over valid/ready and returns a registered result with flags.
//   Single-cycle ops take 1 cycle; MUL runs as an iterative shift-add over WIDTH cycles.
//   It sits between decode/operand fetch and writeback, and the pipeline stalls on in_ready.
// PARAMETERS
//   WIDTH   16  operand/result width in bits (>=4); `WORD datapath when 16
//   MUL_EN  1   1: MUL is iterative over WIDTH cycles; 0: MUL is single-cycle and returns 0 with err=1
// PORTS
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      operands/op presented
//   in_ready   out  1      block can accept this cycle
//   op         in   3      0 ADD, 1 SUB(X-Y), 2 AND, 3 OR, 4 XOR, 5 SLT(signed), 6 SHR(logical), 7 MUL
//   x          in   WIDTH  operand X
//   y          in   WIDTH  operand Y
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      consumer takes result
//   z          out  WIDTH  result
//   zero       out  1      z==0
//   carry      out  1      ADD carry-out; SUB borrow (X<Y unsigned); 0 for all other ops
//   ovf        out  1      signed overflow for ADD/SUB; MUL: high WIDTH bits of product !=0; 0 otherwise
//   err        out  1      MUL requested with MUL_EN=0
//   busy       out  1      state==BUSY
// BEHAVIOUR
//   Reset (async, reset_n=0): state=IDLE; out_valid=0, z=0, zero/carry/ovf/err=0, busy=0,
//     multiplier regs and counter cleared. A transaction in flight is discarded with no output.
//   FSM IDLE -> (accept, op!=MUL or MUL_EN=0) -> DONE; IDLE -> (accept, MUL, MUL_EN=1) -> BUSY;
//     BUSY -> (count==WIDTH-1) -> DONE; DONE -> (out_ready & !in_valid) -> IDLE;
//     DONE -> (out_ready & in_valid) -> DONE or BUSY (back-to-back accept).
//   in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready at posedge.
//   Single-cycle latency: accept at edge k -> out_valid=1 with result after edge k.
//   MUL latency: accept at edge k -> busy for WIDTH cycles -> out_valid after edge k+WIDTH.
//     Product is unsigned; z = low WIDTH bits; one multiplier bit per cycle, LSB first.
//   Output hold: while out_valid & !out_ready, z and flags stay stable and in_ready=0.
//   out_valid=0 in IDLE and BUSY. in_valid during BUSY is ignored (no accept, no corruption).
//   Arithmetic: all mod 2^WIDTH. SLT: z=1 if signed x<y, else 0. SHR: z = x >> y;
//     shift amount >= WIDTH gives z=0. zero is computed on the final z for every op.
//   x/y/op are captured on accept; later input changes do not affect the result.
// TESTING
//   1 ADD x=16'hFFFF y=1 -> z=0, zero=1, carry=1, ovf=0, out_valid one cycle after accept.
//   2 SUB x=16'h8000 y=1 -> z=16'h7FFF, ovf=1, carry=0; SUB x=3 y=5 -> z=16'hFFFE, carry=1.
//   3 MUL x=300 y=300 (WIDTH=16) -> z=16'h5F90, ovf=1; busy for 16 cycles, out_valid at edge k+16,
//     in_valid pulses during BUSY produce no accept.
//   4 Back-to-back: hold out_ready=1, stream ADD, XOR, SLT(x=-1,y=0 -> z=1), SHR(y=16 -> z=0)
//     -> one result per cycle, no bubbles. Then drop out_ready for 3 cycles -> z held, in_ready=0.
//   5 Assert reset_n=0 mid-MUL (cycle 5) -> all outputs 0 immediately; after release, ADD 2+2 -> z=4.
//   6 MUL_EN=0 build: MUL x=3 y=4 -> single cycle, z=0, err=1; next ADD -> err=0.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, iterative shift-add MUL.
// Results and flags are registered and held until the consumer asserts out_ready.
module alu_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err,
  output logic             busy
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
    OP_XOR = 3'd4, OP_SLT = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam int unsigned      CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SH_LIM   = WIDTH'(WIDTH);

  state_e r_state, w_state_next;

  logic [WIDTH-1:0]   r_z;
  logic               r_zero, r_carry, r_ovf, r_err;
  logic [2*WIDTH-1:0] r_mcand, r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept, w_start_mul, w_last;
  logic [WIDTH:0]     w_sum, w_diff;
  logic [WIDTH-1:0]   w_z;
  logic               w_carry, w_ovf, w_err;
  logic [2*WIDTH-1:0] w_acc_next;

  assign in_ready    = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_start_mul = w_accept && (op == OP_MUL) && MUL_EN;
  assign w_last      = (r_state == S_BUSY) && (r_cnt == CNT_LAST);

  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_BUSY);
  assign z         = r_z;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign err       = r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)                          w_state_next = w_start_mul ? S_BUSY : S_DONE;
        else if (r_state == S_DONE && out_ready) w_state_next = S_IDLE;
      end
      S_BUSY:  if (r_cnt == CNT_LAST) w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Extra top bit of the difference is the unsigned borrow (x < y).
  assign w_sum  = {1'b0, x} + {1'b0, y};
  assign w_diff = {1'b0, x} - {1'b0, y};

  always_comb begin
    w_z     = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    case (op)
      OP_ADD: begin
        w_z     = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (w_sum[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        w_z     = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (x[WIDTH-1] != y[WIDTH-1]) && (w_diff[WIDTH-1] != x[WIDTH-1]);
      end
      OP_AND:  w_z = x & y;
      OP_OR:   w_z = x | y;
      OP_XOR:  w_z = x ^ y;
      OP_SLT:  w_z = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SHR:  w_z = (y >= SH_LIM) ? '0 : (x >> y);
      OP_MUL:  w_err = !MUL_EN;
      default: w_z = '0;
    endcase
  end

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_z      <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_start_mul) begin
      r_mcand  <= {{WIDTH{1'b0}}, x};
      r_mplier <= y;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_z     <= w_z;
      r_zero  <= (w_z == '0);
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
      r_err   <= w_err;
    end else if (r_state == S_BUSY) begin
      // One multiplier bit per cycle, LSB first; multiplicand advances one weight.
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_z     <= w_acc_next[WIDTH-1:0];
        r_zero  <= (w_acc_next[WIDTH-1:0] == '0);
        r_carry <= 1'b0;
        r_ovf   <= |w_acc_next[2*WIDTH-1:WIDTH];
        r_err   <= 1'b0;
      end
    end
  end

endmodule
